mul_cell_arbiter: RTL



---
 rtl/mul_cell_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mul_cell_arbiter.sv
// Two-requester round-robin front end for a shared 32x32 partial-product multiply cell.
// Define MUL_CELL_ARBITER_STATS_EN to add saturating per-requester grant counters.
module mul_cell_arbiter #(
   parameter int RR_INIT = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_src1,
   input  logic [31:0] req0_src2,
   input  logic [1:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_src1,
   input  logic [31:0] req1_src2,
   input  logic [1:0]  req1_op,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic [31:0] resp0_data,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp1_data,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_src1_signed,
   output logic        cell_src2_signed,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3,
   input  logic [31:0] cell_p4
`ifdef MUL_CELL_ARBITER_STATS_EN
   ,
   output logic [15:0] grant_cnt0,
   output logic [15:0] grant_cnt1
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, COMBINE, RESP} state_t;

   state_t      state;
   logic        last;
   logic        id;
   logic [1:0]  op_q;
   logic        grant;
   logic        accept;
   logic [1:0]  sel_op;
   logic [63:0] p2_ext;
   logic [63:0] p3_ext;
   logic [63:0] prod;
   logic [31:0] result;

   // With both valid, the requester not granted last wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) grant = ~last;
      else                          grant = req1_valid;
   end

   assign req0_ready = (state == IDLE) && (req0_valid || req1_valid) && !grant;
   assign req1_ready = (state == IDLE) && (req0_valid || req1_valid) &&  grant;
   assign accept     = req0_ready || req1_ready;
   assign sel_op     = grant ? req1_op : req0_op;

   // Middle partial products carry the sign of whichever high half fed them.
   always_comb begin
      p2_ext = cell_src2_signed ? {{32{cell_p2[31]}}, cell_p2} : {32'd0, cell_p2};
      p3_ext = cell_src1_signed ? {{32{cell_p3[31]}}, cell_p3} : {32'd0, cell_p3};
      prod   = {32'd0, cell_p1} + (p2_ext << 16) + (p3_ext << 16) + {cell_p4, 32'd0};
      result = (op_q == 2'd0) ? prod[31:0] : prod[63:32];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         last             <= (RR_INIT == 0);
         id               <= 1'b0;
         op_q             <= 2'd0;
         cell_en          <= 1'b0;
         cell_src1        <= 32'd0;
         cell_src2        <= 32'd0;
         cell_src1_signed <= 1'b0;
         cell_src2_signed <= 1'b0;
         resp0_valid      <= 1'b0;
         resp1_valid      <= 1'b0;
         resp0_data       <= 32'd0;
         resp1_data       <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  id               <= grant;
                  op_q             <= sel_op;
                  cell_src1        <= grant ? req1_src1 : req0_src1;
                  cell_src2        <= grant ? req1_src2 : req0_src2;
                  cell_src1_signed <= (sel_op == 2'd1) || (sel_op == 2'd2);
                  cell_src2_signed <= (sel_op == 2'd1);
                  cell_en          <= 1'b1;
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               cell_en <= 1'b0;
               state   <= COMBINE;
            end
            COMBINE: begin
               if (id) begin
                  resp1_data  <= result;
                  resp1_valid <= 1'b1;
               end else begin
                  resp0_data  <= result;
                  resp0_valid <= 1'b1;
               end
               state <= RESP;
            end
            RESP: begin
               if (id ? resp1_ready : resp0_ready) begin
                  resp0_valid <= 1'b0;
                  resp1_valid <= 1'b0;
                  last        <= id;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MUL_CELL_ARBITER_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_cnt0 <= 16'd0;
         grant_cnt1 <= 16'd0;
      end else begin
         if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
`endif

endmodule
